instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter RESET_PC, default 0, SHALL be the XLEN-bit PC value loaded at reset.
REQ-002 clk  input  1  the only clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, synchronous and active-low.
REQ-004 mem_ready  input  1  memory accepts or completes the current request this cycle.
REQ-005 mem_rdata  input  XLEN  memory read data, valid when mem_ready=1.
REQ-006 opcode  input  opcode_t  decoded opcode of ir, driven combinationally by the hart's decoder.
REQ-007 ir  output  ILEN  instruction register, feeds the decoder.
REQ-008 pc  output  XLEN  address of the current instruction.
REQ-009 mem_req  output  1  memory request valid.
REQ-010 mem_we  output  1  request is a write (store).
REQ-011 mem_addr_sel  output  1  0 = pc, 1 = ALU result.
REQ-012 alu_src_imm  output  1  ALU operand B: 0 = rs2 value, 1 = immediate.
REQ-013 rf_we  output  1  register-file write enable.
REQ-014 rf_wdata_sel  output  1  0 = ALU result, 1 = mdr.
REQ-015 mdr  output  XLEN  latched load data.
REQ-016 retired  output  1  one-cycle pulse when an instruction completes.
REQ-017 halted  output  1  sequencer stopped on an unknown opcode.

Function
REQ-018 States SHALL be FETCH, DECODE, EXECUTE, MEM, WB, HALT; all outputs are Moore except where stated.
REQ-019 FETCH: mem_req=1, mem_we=0, mem_addr_sel=0; on mem_ready: ir<=mem_rdata, go to DECODE; otherwise hold FETCH with request asserted.
REQ-020 DECODE (1 cycle): OPCODE_OP or OPCODE_OP_IMM -> EXECUTE; OPCODE_LOAD or OPCODE_STORE -> MEM; OPCODE_UNKNOWN -> HALT.
REQ-021 EXECUTE (1 cycle): rf_we=1, rf_wdata_sel=0, alu_src_imm=1 iff opcode==OPCODE_OP_IMM; pc<=pc+4; retired=1; go to FETCH.
REQ-022 MEM: mem_req=1, mem_addr_sel=1, alu_src_imm=1, mem_we=1 iff STORE; hold until mem_ready.
REQ-023 MEM with mem_ready: LOAD -> mdr<=mem_rdata, go to WB; STORE -> pc<=pc+4, retired=1 (Mealy, same cycle), go to FETCH.
REQ-024 WB (1 cycle): rf_we=1, rf_wdata_sel=1, pc<=pc+4, retired=1; go to FETCH.
REQ-025 HALT: terminal until reset; halted=1, mem_req=0, rf_we=0; pc and ir frozen.
REQ-026 mem_ready SHALL be ignored when mem_req=0; ir and mdr change only on an accepted handshake.
REQ-027 pc+4 SHALL wrap modulo 2^XLEN (0xFFFFFFFC -> 0x0).
REQ-028 Latency with zero-wait memory: OP/OP_IMM 3 cycles, STORE 3, LOAD 4; each memory wait cycle adds 1.
REQ-029 rf_we SHALL never be asserted in the same cycle as mem_req.

Reset
REQ-030 reset_n=0 at a rising edge SHALL, from any state including mid-handshake, set state=FETCH, pc=RESET_PC, ir=0, mdr=0.
REQ-031 During reset, mem_req, mem_we, rf_we, retired, halted, mem_addr_sel, alu_src_imm, rf_wdata_sel SHALL be 0.
REQ-032 The first cycle after reset deassertion SHALL assert mem_req with pc=RESET_PC.

Structure
REQ-033 seq_state_t enum SHALL live in the shared isa_types package next to opcode_t; XLEN/ILEN come from there.
REQ-034 No sub-module; the instruction decoder is instantiated beside this block at hart level, not inside it.

Verification
REQ-035 Reset, then ADDI word with mem_ready tied 1 -> mem_req cycles 1, rf_we=1 alu_src_imm=1 cycle 3, retired cycle 3, pc 0->4.
REQ-036 LOAD with mem_ready low 2 cycles in MEM -> mem_req held 3 cycles, mdr=mem_rdata, WB rf_wdata_sel=1, total 6 cycles.
REQ-037 STORE -> MEM cycle mem_we=1 mem_addr_sel=1, retired on the same cycle as mem_ready, rf_we never 1.
REQ-038 Fetch word with opcode 0b1101111 (unknown) -> HALT, halted=1, mem_req=0 for 10+ cycles, pc unchanged.
REQ-039 RESET_PC=0xFFFFFFFC, OP instruction -> pc becomes 0x0 after retire.
REQ-040 reset_n low during MEM wait (mem_req=1) -> next cycle state FETCH, pc=RESET_PC, mdr=0, no retire pulse.

Source files
------------

// File: rtl/isa_types.sv
// Shared ISA-level types for the hart: data/instruction widths, decoded opcode, sequencer states.
// No logic; types and constants only.
// Imported by the sequencer and by the hart-level decoder that drives its opcode input.
package isa_types;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  // Decoded major opcode classes produced by the hart decoder from ir.
  typedef enum logic [2:0] {
    OPCODE_OP      = 3'd0,
    OPCODE_OP_IMM  = 3'd1,
    OPCODE_LOAD    = 3'd2,
    OPCODE_STORE   = 3'd3,
    OPCODE_UNKNOWN = 3'd4
  } opcode_t;

  // Multi-cycle instruction sequencer states.
  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    HALT    = 3'd5
  } seq_state_t;

endpackage

// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer: fetch, decode, execute/memory, writeback; owns pc, ir and mdr.
// Latency with zero-wait memory: OP/OP_IMM 3 cycles, STORE 3, LOAD 4; +1 per memory wait cycle.
// Memory backpressure: FETCH and MEM hold mem_req asserted until mem_ready; mem_ready ignored otherwise.
module instr_sequencer
  import isa_types::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  input  opcode_t         opcode,
  output logic [ILEN-1:0] ir,
  output logic [XLEN-1:0] pc,
  output logic            mem_req,
  output logic            mem_we,
  output logic            mem_addr_sel,
  output logic            alu_src_imm,
  output logic            rf_we,
  output logic            rf_wdata_sel,
  output logic [XLEN-1:0] mdr,
  output logic            retired,
  output logic            halted
);

  seq_state_t state_q;
  seq_state_t state_d;

  // Register-update strobes; pc_inc doubles as the retire pulse.
  logic ir_load;
  logic mdr_load;
  logic pc_inc;

  // Next-state and control decode; opcode is stable while ir is held, so MEM can use it directly.
  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    alu_src_imm  = 1'b0;
    rf_we        = 1'b0;
    rf_wdata_sel = 1'b0;
    halted       = 1'b0;
    ir_load      = 1'b0;
    mdr_load     = 1'b0;
    pc_inc       = 1'b0;

    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        case (opcode)
          OPCODE_OP, OPCODE_OP_IMM:  state_d = EXECUTE;
          OPCODE_LOAD, OPCODE_STORE: state_d = MEM;
          default:                   state_d = HALT;
        endcase
      end
      EXECUTE: begin
        rf_we       = 1'b1;
        alu_src_imm = (opcode == OPCODE_OP_IMM);
        pc_inc      = 1'b1;
        state_d     = FETCH;
      end
      MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        alu_src_imm  = 1'b1;
        mem_we       = (opcode == OPCODE_STORE);
        if (mem_ready) begin
          if (opcode == OPCODE_STORE) begin
            // Store completes on the accepting cycle: retire without a WB step.
            pc_inc  = 1'b1;
            state_d = FETCH;
          end else begin
            mdr_load = 1'b1;
            state_d  = WB;
          end
        end
      end
      WB: begin
        rf_we        = 1'b1;
        rf_wdata_sel = 1'b1;
        pc_inc       = 1'b1;
        state_d      = FETCH;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_d = FETCH;
    endcase

    // Hold every control output quiet while reset is asserted, whatever state is registered.
    if (!reset_n) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      alu_src_imm  = 1'b0;
      rf_we        = 1'b0;
      rf_wdata_sel = 1'b0;
      halted       = 1'b0;
      ir_load      = 1'b0;
      mdr_load     = 1'b0;
      pc_inc       = 1'b0;
    end
  end

  assign retired = pc_inc;

  // State, pc, ir and mdr registers; pc+4 wraps naturally at XLEN bits.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      mdr     <= '0;
    end else begin
      state_q <= state_d;
      if (ir_load)  ir  <= mem_rdata;
      if (mdr_load) mdr <= mem_rdata;
      if (pc_inc)   pc  <= pc + XLEN'(4);
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a small opcode decoder standing in for the hart decoder.
// A second instance with RESET_PC at the top of the address space exercises pc wrap.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_instr_sequencer;
  import isa_types::*;

  localparam logic [31:0] W_ADDI = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] W_ADD  = 32'h0020_81b3; // add x3,x1,x2
  localparam logic [31:0] W_LW   = 32'h0000_a103; // lw x2,0(x1)
  localparam logic [31:0] W_SW   = 32'h0020_a023; // sw x2,0(x1)
  localparam logic [31:0] W_JAL  = 32'h0000_006f; // opcode 1101111, unsupported

  logic            clk;
  logic            reset_n;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;
  opcode_t         opcode, opcode2;

  logic [ILEN-1:0] ir, ir2;
  logic [XLEN-1:0] pc, pc2, mdr, mdr2;
  logic mem_req, mem_we, mem_addr_sel, alu_src_imm, rf_we, rf_wdata_sel, retired, halted;
  logic mem_req2, mem_we2, mem_addr_sel2, alu_src_imm2, rf_we2, rf_wdata_sel2, retired2, halted2;

  int n_checks = 0;
  int n_errors = 0;
  logic overlap_seen = 1'b0;

  function automatic opcode_t decode_word(input logic [31:0] w);
    case (w[6:0])
      7'b0110011: return OPCODE_OP;
      7'b0010011: return OPCODE_OP_IMM;
      7'b0000011: return OPCODE_LOAD;
      7'b0100011: return OPCODE_STORE;
      default:    return OPCODE_UNKNOWN;
    endcase
  endfunction

  assign opcode  = decode_word(ir);
  assign opcode2 = decode_word(ir2);

  instr_sequencer dut (
    .clk(clk), .reset_n(reset_n), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .opcode(opcode), .ir(ir), .pc(pc), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .alu_src_imm(alu_src_imm), .rf_we(rf_we),
    .rf_wdata_sel(rf_wdata_sel), .mdr(mdr), .retired(retired), .halted(halted)
  );

  instr_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_hi (
    .clk(clk), .reset_n(reset_n), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .opcode(opcode2), .ir(ir2), .pc(pc2), .mem_req(mem_req2), .mem_we(mem_we2),
    .mem_addr_sel(mem_addr_sel2), .alu_src_imm(alu_src_imm2), .rf_we(rf_we2),
    .rf_wdata_sel(rf_wdata_sel2), .mdr(mdr2), .retired(retired2), .halted(halted2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // rf_we and mem_req are both Moore outputs, so mid-cycle sampling sees their settled values.
  always @(negedge clk) begin
    if (reset_n && rf_we && mem_req) overlap_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One reset edge, then release reset at a falling edge; the following cycle is FETCH.
  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;

    // Reset state, outputs gated low during reset
    @(negedge clk); #1;
    check("rst_pc",        pc, 32'h0);
    check("rst_pc_hi",     pc2, 32'hFFFF_FFFC);
    check("rst_ir",        ir, 32'h0);
    check("rst_mdr",       mdr, 32'h0);
    check("rst_mem_req",   32'(mem_req), 32'd0);
    check("rst_mem_we",    32'(mem_we), 32'd0);
    check("rst_rf_we",     32'(rf_we), 32'd0);
    check("rst_retired",   32'(retired), 32'd0);
    check("rst_halted",    32'(halted), 32'd0);
    check("rst_addr_sel",  32'(mem_addr_sel), 32'd0);
    check("rst_src_imm",   32'(alu_src_imm), 32'd0);
    check("rst_wdata_sel", 32'(rf_wdata_sel), 32'd0);

    // ADDI, zero-wait memory
    @(negedge clk); reset_n = 1'b1; mem_ready = 1'b1; mem_rdata = W_ADDI; #1;
    check("addi_c1_req",     32'(mem_req), 32'd1);
    check("addi_c1_pc",      pc, 32'h0);
    check("addi_c1_we",      32'(mem_we), 32'd0);
    check("addi_c1_addrsel", 32'(mem_addr_sel), 32'd0);
    @(negedge clk); #1;
    check("addi_c2_ir",      ir, W_ADDI);
    check("addi_c2_req",     32'(mem_req), 32'd0);
    check("addi_c2_retired", 32'(retired), 32'd0);
    @(negedge clk); #1;
    check("addi_c3_rf_we",   32'(rf_we), 32'd1);
    check("addi_c3_srcimm",  32'(alu_src_imm), 32'd1);
    check("addi_c3_wsel",    32'(rf_wdata_sel), 32'd0);
    check("addi_c3_retired", 32'(retired), 32'd1);
    check("addi_c3_req",     32'(mem_req), 32'd0);
    @(negedge clk); mem_ready = 1'b0; #1;
    check("addi_c4_pc",      pc, 32'h4);
    check("addi_c4_req",     32'(mem_req), 32'd1);
    check("addi_c4_retired", 32'(retired), 32'd0);

    // OP on both instances: pc 0 -> 4 and 0xFFFFFFFC -> 0
    do_reset(); mem_ready = 1'b1; mem_rdata = W_ADD; #1;
    check("op_c1_req_hi", 32'(mem_req2), 32'd1);
    check("op_c1_pc_hi",  pc2, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("op_c3_srcimm",  32'(alu_src_imm), 32'd0);
    check("op_c3_rf_we",   32'(rf_we), 32'd1);
    check("op_c3_retired", 32'(retired2), 32'd1);
    @(negedge clk); mem_ready = 1'b0; #1;
    check("op_pc",      pc, 32'h4);
    check("op_pc_wrap", pc2, 32'h0);

    // STORE with one fetch wait and one MEM wait
    do_reset(); mem_ready = 1'b0; mem_rdata = W_SW; #1;
    check("sw_fwait_req", 32'(mem_req), 32'd1);
    check("sw_fwait_ir",  ir, 32'h0);
    @(negedge clk); mem_ready = 1'b1; #1;
    check("sw_fetch_req", 32'(mem_req), 32'd1);
    @(negedge clk); mem_ready = 1'b0; #1;
    check("sw_dec_ir", ir, W_SW);
    @(negedge clk); #1;
    check("sw_mwait_we",      32'(mem_we), 32'd1);
    check("sw_mwait_addrsel", 32'(mem_addr_sel), 32'd1);
    check("sw_mwait_srcimm",  32'(alu_src_imm), 32'd1);
    check("sw_mwait_retired", 32'(retired), 32'd0);
    check("sw_mwait_rf_we",   32'(rf_we), 32'd0);
    @(negedge clk); mem_ready = 1'b1; #1;
    check("sw_mem_retired", 32'(retired), 32'd1);
    check("sw_mem_we",      32'(mem_we), 32'd1);
    check("sw_mem_rf_we",   32'(rf_we), 32'd0);
    @(negedge clk); mem_ready = 1'b0; #1;
    check("sw_next_pc",      pc, 32'h4);
    check("sw_next_retired", 32'(retired), 32'd0);
    check("sw_next_we",      32'(mem_we), 32'd0);
    check("sw_next_req",     32'(mem_req), 32'd1);

    // LOAD with two MEM waits, then reset in the middle of the next load's MEM wait
    do_reset(); mem_ready = 1'b1; mem_rdata = W_LW; #1;
    check("lw_c1_req", 32'(mem_req), 32'd1);
    @(negedge clk); mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1;
    check("lw_dec_ir",  ir, W_LW);
    check("lw_dec_req", 32'(mem_req), 32'd0);
    @(negedge clk); mem_ready = 1'b0; #1;
    check("lw_ign_ir",      ir, W_LW);
    check("lw_ign_mdr",     mdr, 32'h0);
    check("lw_m1_req",      32'(mem_req), 32'd1);
    check("lw_m1_addrsel",  32'(mem_addr_sel), 32'd1);
    check("lw_m1_we",       32'(mem_we), 32'd0);
    check("lw_m1_srcimm",   32'(alu_src_imm), 32'd1);
    @(negedge clk); #1;
    check("lw_m2_req", 32'(mem_req), 32'd1);
    check("lw_m2_mdr", mdr, 32'h0);
    @(negedge clk); mem_ready = 1'b1; mem_rdata = 32'hCAFE_1234; #1;
    check("lw_m3_req",     32'(mem_req), 32'd1);
    check("lw_m3_retired", 32'(retired), 32'd0);
    @(negedge clk); mem_ready = 1'b0; #1;
    check("lw_wb_mdr",     mdr, 32'hCAFE_1234);
    check("lw_wb_rf_we",   32'(rf_we), 32'd1);
    check("lw_wb_wsel",    32'(rf_wdata_sel), 32'd1);
    check("lw_wb_retired", 32'(retired), 32'd1);
    check("lw_wb_req",     32'(mem_req), 32'd0);
    @(negedge clk); mem_ready = 1'b1; mem_rdata = W_LW; #1;
    check("lw_next_pc",  pc, 32'h4);
    check("lw_next_req", 32'(mem_req), 32'd1);
    @(negedge clk); mem_ready = 1'b0; #1;
    @(negedge clk); #1;
    check("lw2_mwait_req", 32'(mem_req), 32'd1);
    @(negedge clk); reset_n = 1'b0; #1;
    check("midrst_req",     32'(mem_req), 32'd0);
    check("midrst_retired", 32'(retired), 32'd0);
    @(negedge clk); reset_n = 1'b1; #1;
    check("midrst_pc",      pc, 32'h0);
    check("midrst_mdr",     mdr, 32'h0);
    check("midrst_ir",      ir, 32'h0);
    check("midrst_req",     32'(mem_req), 32'd1);
    check("midrst_addrsel", 32'(mem_addr_sel), 32'd0);
    check("midrst_retired", 32'(retired), 32'd0);

    // Unknown opcode: terminal HALT with pc and ir frozen
    do_reset(); mem_ready = 1'b1; mem_rdata = W_JAL; #1;
    @(negedge clk); mem_rdata = 32'h1234_5678; #1;
    check("halt_dec_ir", ir, W_JAL);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      check("halt_halted", 32'(halted), 32'd1);
      check("halt_req",    32'(mem_req), 32'd0);
      check("halt_rf_we",  32'(rf_we), 32'd0);
      check("halt_pc",     pc, 32'h0);
      check("halt_ir",     ir, W_JAL);
    end

    check("rf_we_with_mem_req", 32'(overlap_seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
